// File: rtl/mem_l1_l2_bridge_pkg.sv
// ---------------------------------------------------------------------------
// mem_l1_l2_bridge_pkg
// Shared memory-side definitions for the L1 -> L2 bridge:
//   - L1 operation / handshake encodings (READY/OK/HOLD/FAULT)
//   - tile and address widths
//   - bridge FSM state encoding
//   - helper that builds the fault word returned to the L1
// ---------------------------------------------------------------------------
package mem_l1_l2_bridge_pkg;

  localparam int unsigned UMEM_TILE_W = 128;
  localparam int unsigned UMEM_ADDR_W = 48;
  localparam int unsigned UMEM_OPM_W  = 5;
  localparam int unsigned UMEM_EXC_W  = 16;

  // Only opm[4:0] is significant; zero means no request.
  localparam logic [4:0] UMEM_OPM_READY = 5'h00;

  localparam logic [1:0] UMEM_OK_READY = 2'd0;
  localparam logic [1:0] UMEM_OK_OK    = 2'd1;
  localparam logic [1:0] UMEM_OK_HOLD  = 2'd2;
  localparam logic [1:0] UMEM_OK_FAULT = 2'd3;

  // Bridge FSM encoding.
  localparam logic [1:0] BR_IDLE  = 2'd0;
  localparam logic [1:0] BR_ISSUE = 2'd1;
  localparam logic [1:0] BR_WAIT  = 2'd2;
  localparam logic [1:0] BR_DONE  = 2'd3;

  typedef logic [UMEM_TILE_W-1:0] umemTile_t;

  // A fault carries its exception code in the low 16 bits, rest zero.
  function automatic umemTile_t umemFaultWord(input logic [UMEM_EXC_W-1:0] exc);
    return {{(UMEM_TILE_W - UMEM_EXC_W){1'b0}}, exc};
  endfunction

endpackage

// File: rtl/mem_l1_l2_bridge_tmo.sv
// ---------------------------------------------------------------------------
// mem_bridge_tmo
// Per-request timeout counter for the L1 -> L2 bridge. Counts cycles while
// run is high and flags expiry on the TIMEOUT-th such cycle, so the bridge
// leaves ISSUE/WAIT on that edge. The count saturates and never wraps.
// Ports:
//   clock   in  : rising-edge clock
//   reset   in  : synchronous, active-high
//   run     in  : bridge is in ISSUE or WAIT
//   clear   in  : restart the count (bridge idle)
//   expired out : this run cycle is the last one allowed
// ---------------------------------------------------------------------------
module mem_bridge_tmo #(
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic clock,
  input  logic reset,
  input  logic run,
  input  logic clear,
  output logic expired
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] SAT  = CW'(TIMEOUT);

  logic [CW-1:0] count_r;

  // Cycle counter: cleared while idle, advances in run cycles, saturates.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_r <= {CW{1'b0}};
    end else if (clear) begin
      count_r <= {CW{1'b0}};
    end else if (run && (count_r < SAT)) begin
      count_r <= count_r + CW'(1);
    end else begin
      count_r <= count_r;
    end
  end

  // The count holds the number of completed run cycles, so the current
  // cycle is the TIMEOUT-th one when the count reads TIMEOUT-1.
  assign expired = run && (count_r >= LAST);

endmodule

// File: rtl/mem_l1_l2_bridge.sv
// ---------------------------------------------------------------------------
// mem_l1_l2_bridge
// Converts one L1 hold-style request (READY/OK/HOLD/FAULT) into a
// valid/ready request plus strobed response on the L2 fabric port, with a
// per-request timeout so the L1 can never deadlock on a lost response.
// Ports:
//   clock, reset          : rising-edge clock, synchronous active-high reset
//   l1Addr/l1AddrB        : request addresses, forwarded unmodified
//   l1Opm                 : operation, bits [4:0] significant, 0 = no request
//   l1DataIn              : store/swap data
//   l1DataOut, l1OK       : returned tile/fault word and handshake code
//   l2Req*                : request channel (valid/ready, registered payload)
//   l2Rsp*                : single-cycle response strobe and payload
//   strayRsp              : sticky, response seen outside WAIT
// ---------------------------------------------------------------------------
module mem_l1_l2_bridge
  import mem_l1_l2_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT = 1023,
  parameter logic [15:0] EXC_TMO = 16'h8000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [47:0]       l1Addr,
  input  logic [47:0]       l1AddrB,
  input  logic [15:0]       l1Opm,
  input  logic [127:0]      l1DataIn,
  output logic [127:0]      l1DataOut,
  output logic [1:0]        l1OK,
  output logic              l2ReqValid,
  input  logic              l2ReqReady,
  output logic [47:0]       l2ReqAddr,
  output logic [47:0]       l2ReqAddrB,
  output logic [4:0]        l2ReqOpm,
  output logic [127:0]      l2ReqData,
  input  logic              l2RspValid,
  input  logic [127:0]      l2RspData,
  input  logic              l2RspFault,
  input  logic [15:0]       l2RspExc,
  output logic              strayRsp
);

  logic [1:0] state_r;
  logic       fault_r;
  logic [1:0] stateNext_s;
  logic       faultNext_s;
  umemTile_t  wordNext_s;
  logic [1:0] okNext_s;
  logic       capture_s;
  logic       opmActive_s;
  logic       stray_s;
  logic       tmoRun_s;
  logic       tmoClear_s;
  logic       tmoExpired_s;
  logic       unusedOpmHi_s;

  // Upper opm bits carry no meaning for this bridge.
  assign unusedOpmHi_s = ^l1Opm[15:5];

  assign opmActive_s = (l1Opm[4:0] != UMEM_OPM_READY);
  assign tmoRun_s    = (state_r == BR_ISSUE) || (state_r == BR_WAIT);
  assign tmoClear_s  = (state_r == BR_IDLE);
  // Responses are only consumed in WAIT; anything else is a late or bogus one.
  assign stray_s     = l2RspValid && (state_r != BR_WAIT);

  mem_bridge_tmo #(
    .TIMEOUT (TIMEOUT)
  ) uTmo (
    .clock   (clock),
    .reset   (reset),
    .run     (tmoRun_s),
    .clear   (tmoClear_s),
    .expired (tmoExpired_s)
  );

  // Next-state, result word and the Moore output code for the next state.
  always_comb begin
    stateNext_s = state_r;
    faultNext_s = fault_r;
    wordNext_s  = l1DataOut;
    capture_s   = 1'b0;
    case (state_r)
      BR_IDLE: begin
        if (opmActive_s) begin
          stateNext_s = BR_ISSUE;
          capture_s   = 1'b1;
        end else begin
          stateNext_s = BR_IDLE;
        end
      end
      BR_ISSUE: begin
        // Timeout beats a same-cycle accept; that request's response goes stray.
        if (tmoExpired_s) begin
          stateNext_s = BR_DONE;
          faultNext_s = 1'b1;
          wordNext_s  = umemFaultWord(EXC_TMO);
        end else if (l2ReqReady) begin
          stateNext_s = BR_WAIT;
        end else begin
          stateNext_s = BR_ISSUE;
        end
      end
      BR_WAIT: begin
        // A response in the final allowed cycle still wins over the timeout.
        if (l2RspValid) begin
          stateNext_s = BR_DONE;
          faultNext_s = l2RspFault;
          if (l2RspFault) begin
            wordNext_s = umemFaultWord(l2RspExc);
          end else begin
            wordNext_s = l2RspData;
          end
        end else if (tmoExpired_s) begin
          stateNext_s = BR_DONE;
          faultNext_s = 1'b1;
          wordNext_s  = umemFaultWord(EXC_TMO);
        end else begin
          stateNext_s = BR_WAIT;
        end
      end
      BR_DONE: begin
        // Release only once the L1 drops to READY; no re-issue on opm change.
        if (opmActive_s) begin
          stateNext_s = BR_DONE;
        end else begin
          stateNext_s = BR_IDLE;
        end
      end
      default: begin
        stateNext_s = BR_IDLE;
        faultNext_s = 1'b0;
      end
    endcase

    case (stateNext_s)
      BR_IDLE:  okNext_s = UMEM_OK_READY;
      BR_ISSUE: okNext_s = UMEM_OK_HOLD;
      BR_WAIT:  okNext_s = UMEM_OK_HOLD;
      BR_DONE:  okNext_s = faultNext_s ? UMEM_OK_FAULT : UMEM_OK_OK;
      default:  okNext_s = UMEM_OK_READY;
    endcase
  end

  // State, registered handshake outputs, captured payload and stray flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r    <= BR_IDLE;
      fault_r    <= 1'b0;
      l1OK       <= UMEM_OK_READY;
      l2ReqValid <= 1'b0;
      l2ReqAddr  <= 48'h0;
      l2ReqAddrB <= 48'h0;
      l2ReqOpm   <= 5'h00;
      l2ReqData  <= {UMEM_TILE_W{1'b0}};
      l1DataOut  <= {UMEM_TILE_W{1'b0}};
      strayRsp   <= 1'b0;
    end else begin
      state_r    <= stateNext_s;
      fault_r    <= faultNext_s;
      l1OK       <= okNext_s;
      l2ReqValid <= (stateNext_s == BR_ISSUE);
      l1DataOut  <= wordNext_s;
      if (capture_s) begin
        l2ReqAddr  <= l1Addr;
        l2ReqAddrB <= l1AddrB;
        l2ReqOpm   <= l1Opm[4:0];
        l2ReqData  <= l1DataIn;
      end
      if (stray_s) begin
        strayRsp <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_l1_l2_bridge.sv
// ---------------------------------------------------------------------------
// tb_mem_l1_l2_bridge
// Directed scenarios with literal expectations, followed by randomized
// traffic. A transaction-level model (phase + elapsed-cycle count) predicts
// every output; a negedge process compares the DUT against it each cycle.
// ---------------------------------------------------------------------------
module tb_mem_l1_l2_bridge;

  localparam int TMO = 8;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic [47:0]  l1Addr = 48'h0;
  logic [47:0]  l1AddrB = 48'h0;
  logic [15:0]  l1Opm = 16'h0;
  logic [127:0] l1DataIn = 128'h0;
  logic [127:0] l1DataOut;
  logic [1:0]   l1OK;
  logic         l2ReqValid;
  logic         l2ReqReady = 1'b0;
  logic [47:0]  l2ReqAddr;
  logic [47:0]  l2ReqAddrB;
  logic [4:0]   l2ReqOpm;
  logic [127:0] l2ReqData;
  logic         l2RspValid = 1'b0;
  logic [127:0] l2RspData = 128'h0;
  logic         l2RspFault = 1'b0;
  logic [15:0]  l2RspExc = 16'h0;
  logic         strayRsp;

  mem_l1_l2_bridge #(.TIMEOUT(TMO), .EXC_TMO(16'h8000)) dut (
    .clock(clock), .reset(reset),
    .l1Addr(l1Addr), .l1AddrB(l1AddrB), .l1Opm(l1Opm), .l1DataIn(l1DataIn),
    .l1DataOut(l1DataOut), .l1OK(l1OK),
    .l2ReqValid(l2ReqValid), .l2ReqReady(l2ReqReady),
    .l2ReqAddr(l2ReqAddr), .l2ReqAddrB(l2ReqAddrB), .l2ReqOpm(l2ReqOpm), .l2ReqData(l2ReqData),
    .l2RspValid(l2RspValid), .l2RspData(l2RspData), .l2RspFault(l2RspFault), .l2RspExc(l2RspExc),
    .strayRsp(strayRsp)
  );

  always #5 clock = ~clock;

  int checkCount = 0;
  int passCount  = 0;
  bit cmpOn      = 1'b0;

  // Model: 0 idle, 1 requesting, 2 awaiting response, 3 reporting to L1.
  int           mPhase = 0;
  int           mAge   = 0;
  bit           mFault = 1'b0;
  logic [47:0]  mAddr  = 48'h0;
  logic [47:0]  mAddrB = 48'h0;
  logic [4:0]   mOpm   = 5'h0;
  logic [127:0] mData  = 128'h0;
  logic [127:0] mOut   = 128'h0;
  bit           mStray = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  function automatic logic [1:0] mOK();
    if (mPhase == 0) return 2'd0;
    else if (mPhase == 3) return mFault ? 2'd3 : 2'd1;
    else return 2'd2;
  endfunction

  // Advance the model by one clock using the inputs present at the edge.
  task automatic modelStep();
    bit act;
    act = (l1Opm[4:0] != 5'h00);
    if (reset) begin
      mPhase = 0; mAge = 0; mFault = 1'b0;
      mAddr = 48'h0; mAddrB = 48'h0; mOpm = 5'h0; mData = 128'h0;
      mOut = 128'h0; mStray = 1'b0;
    end else begin
      if (l2RspValid && mPhase != 2) mStray = 1'b1;
      case (mPhase)
        0: if (act) begin
          mAddr = l1Addr; mAddrB = l1AddrB; mOpm = l1Opm[4:0]; mData = l1DataIn;
          mAge = 0; mPhase = 1;
        end
        1: begin
          mAge++;
          if (mAge >= TMO) begin
            mPhase = 3; mFault = 1'b1; mOut = {112'h0, 16'h8000};
          end else if (l2ReqReady) begin
            mPhase = 2;
          end
        end
        2: begin
          mAge++;
          if (l2RspValid) begin
            mPhase = 3; mFault = l2RspFault;
            mOut = l2RspFault ? {112'h0, l2RspExc} : l2RspData;
          end else if (mAge >= TMO) begin
            mPhase = 3; mFault = 1'b1; mOut = {112'h0, 16'h8000};
          end
        end
        3: if (!act) mPhase = 0;
        default: mPhase = 0;
      endcase
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    modelStep();
    #1;
  endtask

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clock) begin
    if (cmpOn) begin
      check("l1OK", l1OK, mOK());
      check("l2ReqValid", l2ReqValid, mPhase == 1);
      check("l2ReqAddr", l2ReqAddr, mAddr);
      check("l2ReqAddrB", l2ReqAddrB, mAddrB);
      check("l2ReqOpm", l2ReqOpm, mOpm);
      check("l2ReqData", l2ReqData, mData);
      check("l1DataOut", l1DataOut, mOut);
      check("strayRsp", strayRsp, mStray);
    end
  end

  initial begin
    int holds;
    logic [127:0] rd;

    cyc(); cyc();
    cmpOn = 1'b1;
    check("rst l1OK", l1OK, 2'd0);
    check("rst valid", l2ReqValid, 1'b0);
    check("rst dataOut", l1DataOut, 128'h0);
    check("rst addr", l2ReqAddr, 48'h0);
    check("rst stray", strayRsp, 1'b0);

    // Minimum-latency load.
    reset = 1'b0;
    l1Opm = 16'h000B; l1Addr = 48'h0000_1234_5670; l1AddrB = 48'h0000_0000_0ABC;
    l1DataIn = 128'h0; l2ReqReady = 1'b1;
    cyc();
    check("t1 hold1", l1OK, 2'd2);
    check("t1 valid", l2ReqValid, 1'b1);
    check("t1 addr", l2ReqAddr, 48'h0000_1234_5670);
    check("t1 opm", l2ReqOpm, 5'h0B);
    cyc();
    check("t1 hold2", l1OK, 2'd2);
    check("t1 valid drop", l2ReqValid, 1'b0);
    l2RspValid = 1'b1; l2RspData = {16{8'hA5}}; l2RspFault = 1'b0;
    cyc();
    l2RspValid = 1'b0;
    check("t1 ok", l1OK, 2'd1);
    check("t1 data", l1DataOut, {16{8'hA5}});
    check("t1 model data", mOut, {16{8'hA5}});
    l1Opm = 16'h0000;
    cyc();
    check("t1 ready", l1OK, 2'd0);

    // Backpressure for 5 cycles, then a fault response.
    l1Opm = 16'h0003; l1Addr = 48'hDEAD_BEEF_0001; l1AddrB = 48'h0000_0000_0001;
    l1DataIn = {4{32'h1234_5678}}; l2ReqReady = 1'b0;
    cyc();
    for (int i = 0; i < 5; i++) begin
      check("t2 valid", l2ReqValid, 1'b1);
      check("t2 hold", l1OK, 2'd2);
      check("t2 addr", l2ReqAddr, 48'hDEAD_BEEF_0001);
      check("t2 data", l2ReqData, {4{32'h1234_5678}});
      l1Addr = 48'h1111_2222_3333; l1DataIn = 128'h5;
      if (i < 4) cyc();
    end
    l2ReqReady = 1'b1;
    cyc();
    l2RspValid = 1'b1; l2RspFault = 1'b1; l2RspExc = 16'h8003; l2RspData = {4{32'hFFFF_FFFF}};
    cyc();
    l2RspValid = 1'b0; l2RspFault = 1'b0;
    check("t2 fault", l1OK, 2'd3);
    check("t2 exc word", l1DataOut, {112'h0, 16'h8003});
    l1Opm = 16'h0000;
    cyc();

    // Timeout, then a late response and a clean follow-up request.
    l1Opm = 16'h0001; l1Addr = 48'h0000_0000_0040;
    cyc();
    holds = 0;
    for (int i = 0; i < 20 && l1OK == 2'd2; i++) begin
      holds++;
      cyc();
    end
    check("t3 hold count", holds, 8);
    check("t3 fault", l1OK, 2'd3);
    check("t3 tmo word", l1DataOut, {112'h0, 16'h8000});
    l2RspValid = 1'b1; l2RspData = 128'h77;
    cyc();
    l2RspValid = 1'b0;
    check("t3 stray", strayRsp, 1'b1);
    check("t3 still fault", l1OK, 2'd3);
    l1Opm = 16'h0000;
    cyc();
    l1Opm = 16'h000A;
    cyc();
    cyc();
    rd = {$urandom, $urandom, $urandom, $urandom};
    l2RspValid = 1'b1; l2RspData = rd;
    cyc();
    l2RspValid = 1'b0;
    check("t3 next ok", l1OK, 2'd1);
    check("t3 next data", l1DataOut, rd);

    // Opm kept (and changed) after OK: no re-issue, then release on low bits 0.
    for (int i = 0; i < 10; i++) begin
      l1Opm = 16'h0001 + 16'(i);
      cyc();
      check("t4 stays ok", l1OK, 2'd1);
      check("t4 no reissue", l2ReqValid, 1'b0);
    end
    l1Opm = 16'hFFE0;
    cyc();
    check("t4 release", l1OK, 2'd0);

    // Reset during WAIT, then a response that must count as stray.
    l1Opm = 16'h0005;
    cyc();
    cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0; l1Opm = 16'h0000;
    check("t5 l1OK", l1OK, 2'd0);
    check("t5 valid", l2ReqValid, 1'b0);
    check("t5 addr", l2ReqAddr, 48'h0);
    check("t5 opm", l2ReqOpm, 5'h0);
    check("t5 dataOut", l1DataOut, 128'h0);
    check("t5 stray clr", strayRsp, 1'b0);
    l2RspValid = 1'b1;
    cyc();
    l2RspValid = 1'b0;
    check("t5 stray set", strayRsp, 1'b1);

    // Randomized traffic.
    for (int n = 0; n < 1500; n++) begin
      reset = ($urandom_range(0, 299) == 0);
      l1Addr = 48'({$urandom, $urandom});
      l1AddrB = 48'({$urandom, $urandom});
      l1DataIn = {$urandom, $urandom, $urandom, $urandom};
      l2ReqReady = ($urandom_range(0, 1) == 1);
      l2RspData = {$urandom, $urandom, $urandom, $urandom};
      l2RspFault = ($urandom_range(0, 3) == 0);
      l2RspExc = 16'($urandom);
      if (mPhase == 2) l2RspValid = ($urandom_range(0, 9) < 3);
      else l2RspValid = ($urandom_range(0, 49) == 0);
      if (mPhase == 0 || mPhase == 3) begin
        if ($urandom_range(0, 2) == 0) l1Opm = {11'($urandom), 5'h00};
        else l1Opm = 16'($urandom) | 16'h0001;
      end
      cyc();
    end

    reset = 1'b0; l2RspValid = 1'b0; l1Opm = 16'h0000;
    cyc(); cyc();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
